// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake plus the 16-bit ALU pin bundle for alu_op_sequencer.
// slave  : the sequencer side (takes commands, drives the ALU).
// master : the controller + ALU side (issues commands, returns ALU result/flags).
interface alu_op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_funsel;
  logic        alu_wf;
  logic [15:0] alu_out;
  logic [3:0]  alu_flags;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_out, alu_flags,
    input  cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err,
           alu_a, alu_b, alu_funsel, alu_wf
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_out, alu_flags,
    output cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err,
           alu_a, alu_b, alu_funsel, alu_wf
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs 32-bit operations as two chained passes through a
// 16-bit ALU, chaining through the ALU's registered carry flag.
// Optional feature macro: ALUSEQ_ADC32_EN (op 8 = ADC32 when defined,
// otherwise op 8 is reported as illegal).
module alu_op_sequencer #(
  parameter logic [4:0] IDLE_FUNSEL = 5'b10000
) (
  input logic               i_clk,
  input logic               i_rst_n,
  alu_op_sequencer_if.slave io_bus
);

  typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_RESP} state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LSL = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6;
  localparam logic [3:0] OP_ASR = 4'd7;
`ifdef ALUSEQ_ADC32_EN
  localparam logic [3:0] OP_ADC = 4'd8;
`endif

  state_t      r_state, w_next;
  logic [3:0]  r_op;
  logic [31:0] r_a, r_b, r_data;
  logic        r_err;

  logic        w_legal;
  logic        w_hi_first, w_lo_half, w_in_pass;
  logic        w_is_arith, w_is_shift;
  logic [15:0] w_alu_a, w_alu_b;
  logic [4:0]  w_funsel;
  logic        w_alu_wf;
  logic        w_unused;

  // Decode whether the incoming op is one this build can execute.
  always_comb begin
    w_legal = 1'b0;
    case (io_bus.cmd_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_LSL, OP_LSR, OP_ASR: w_legal = 1'b1;
`ifdef ALUSEQ_ADC32_EN
      OP_ADC:                 w_legal = 1'b1;
`endif
      default:                w_legal = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state: illegal ops skip both passes and go straight to a response.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (io_bus.cmd_valid) w_next = w_legal ? S_PASS1 : S_RESP;
      S_PASS1: w_next = S_PASS2;
      S_PASS2: w_next = S_RESP;
      S_RESP:  if (io_bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Right shifts must run the high half first so its bit 0 lands in the carry.
  assign w_hi_first = (r_op == OP_LSR) || (r_op == OP_ASR);
  assign w_in_pass  = (r_state == S_PASS1) || (r_state == S_PASS2);
  assign w_lo_half  = (r_state == S_PASS1) ^ w_hi_first;

  // Command capture on accept, then one result half captured per pass.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op   <= 4'd0;
      r_a    <= 32'd0;
      r_b    <= 32'd0;
      r_data <= 32'd0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (io_bus.cmd_valid) begin
          r_op   <= io_bus.cmd_op;
          r_a    <= io_bus.cmd_a;
          r_b    <= io_bus.cmd_b;
          r_data <= 32'd0;
          r_err  <= !w_legal;
        end
        S_PASS1, S_PASS2: begin
          if (w_lo_half) r_data[15:0]  <= io_bus.alu_out;
          else           r_data[31:16] <= io_bus.alu_out;
        end
        default: ;
      endcase
    end
  end

  // ALU pin drive: operand half and function per pass, idle function otherwise.
  always_comb begin
    w_alu_a  = 16'd0;
    w_alu_b  = 16'd0;
    w_funsel = IDLE_FUNSEL;
    w_alu_wf = 1'b0;
    if (w_in_pass) begin
      w_alu_wf = 1'b1;
      w_alu_a  = w_lo_half ? r_a[15:0] : r_a[31:16];
      w_alu_b  = w_lo_half ? r_b[15:0] : r_b[31:16];
      case (r_op)
        OP_ADD: w_funsel = (r_state == S_PASS1) ? 5'b10100 : 5'b10101;
        OP_SUB: begin
          // High half of a subtract is A + ~B + carry (carry=1 means no borrow).
          if (r_state == S_PASS1) w_funsel = 5'b10110;
          else begin
            w_funsel = 5'b10101;
            w_alu_b  = ~r_b[31:16];
          end
        end
        OP_AND: w_funsel = 5'b10111;
        OP_OR:  w_funsel = 5'b11000;
        OP_XOR: w_funsel = 5'b11001;
        OP_LSL: w_funsel = (r_state == S_PASS1) ? 5'b11011 : 5'b11110;
        OP_LSR: w_funsel = (r_state == S_PASS1) ? 5'b11100 : 5'b11111;
        OP_ASR: w_funsel = (r_state == S_PASS1) ? 5'b11101 : 5'b11111;
`ifdef ALUSEQ_ADC32_EN
        OP_ADC: w_funsel = 5'b10101;
`endif
        default: begin
          w_funsel = IDLE_FUNSEL;
          w_alu_wf = 1'b0;
        end
      endcase
    end
  end

  // Which ops report the ALU's carry and overflow in the response flags.
  always_comb begin
    w_is_arith = 1'b0;
    w_is_shift = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB:         w_is_arith = 1'b1;
`ifdef ALUSEQ_ADC32_EN
      OP_ADC:                 w_is_arith = 1'b1;
`endif
      OP_LSL, OP_LSR, OP_ASR: w_is_shift = 1'b1;
      default: ;
    endcase
  end

  // ALU Z/N are per-half only; the 32-bit Z/N come from the held result.
  assign w_unused = ^{io_bus.alu_flags[3], io_bus.alu_flags[1]};

  assign io_bus.cmd_ready  = i_rst_n && (r_state == S_IDLE);
  assign io_bus.rsp_valid  = (r_state == S_RESP);
  assign io_bus.rsp_data   = r_data;
  assign io_bus.rsp_err    = r_err;
  assign io_bus.rsp_flags  = ((r_state == S_RESP) && !r_err) ?
                             { (r_data == 32'd0),
                               (w_is_arith || w_is_shift) & io_bus.alu_flags[2],
                               r_data[31],
                               w_is_arith & io_bus.alu_flags[0] } : 4'd0;
  assign io_bus.alu_a      = w_alu_a;
  assign io_bus.alu_b      = w_alu_b;
  assign io_bus.alu_funsel = w_funsel;
  assign io_bus.alu_wf     = w_alu_wf;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural 16-bit ALU sits on the ALU pins,
// and every response is compared with a plain 32-bit arithmetic reference.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_op_sequencer_if bus();

  alu_op_sequencer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- 16-bit ALU environment model ----------------
  // returns {carry, overflow, result}; logic ops and idle leave carry alone
  function automatic logic [17:0] alu_f(input logic [4:0] fs, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [15:0] r;
    logic c, v;
    c = cin; v = 1'b0; r = 16'd0;
    case (fs)
      5'b10000: r = a;
      5'b10100: begin s = {1'b0,a} + {1'b0,b};        r = s[15:0]; c = s[16];
                      v = (a[15] == b[15]) && (r[15] != a[15]); end
      5'b10101: begin s = {1'b0,a} + {1'b0,b} + {16'd0,cin}; r = s[15:0]; c = s[16];
                      v = (a[15] == b[15]) && (r[15] != a[15]); end
      5'b10110: begin s = {1'b0,a} + {1'b0,~b} + 17'd1; r = s[15:0]; c = s[16];
                      v = (a[15] != b[15]) && (r[15] != a[15]); end
      5'b10111: r = a & b;
      5'b11000: r = a | b;
      5'b11001: r = a ^ b;
      5'b11011: begin r = {a[14:0], 1'b0};  c = a[15]; end
      5'b11100: begin r = {1'b0, a[15:1]};  c = a[0];  end
      5'b11101: begin r = {a[15], a[15:1]}; c = a[0];  end
      5'b11110: begin r = {a[14:0], cin};   c = a[15]; end
      5'b11111: begin r = {cin, a[15:1]};   c = a[0];  end
      default:  r = 16'd0;
    endcase
    return {c, v, r};
  endfunction

  logic [3:0]  m_flags = 4'd0;
  logic [17:0] m_res;
  always_comb m_res = alu_f(bus.alu_funsel, bus.alu_a, bus.alu_b, m_flags[2]);
  assign bus.alu_out   = m_res[15:0];
  assign bus.alu_flags = m_flags;
  always @(posedge clk)
    if (bus.alu_wf) m_flags <= {(m_res[15:0] == 16'd0), m_res[17], m_res[15], m_res[16]};

  // ---------------- 32-bit reference ----------------
  logic mdl_c = 1'b0;   // carry the ALU holds between commands

  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, output logic [31:0] d, output logic [3:0] f,
                                 output logic err, output logic cout);
    logic [32:0] s;
    logic c, v;
    c = 1'b0; v = 1'b0; err = 1'b0; d = 32'd0; cout = cin;
    case (op)
      4'd0: begin s = {1'b0,a} + {1'b0,b}; d = s[31:0]; c = s[32];
                  v = (a[31] == b[31]) && (d[31] != a[31]); cout = c; end
      4'd1: begin d = a - b; c = (a >= b);
                  v = (a[31] != b[31]) && (d[31] != a[31]); cout = c; end
      4'd2: d = a & b;
      4'd3: d = a | b;
      4'd4: d = a ^ b;
      4'd5: begin d = a << 1; c = a[31]; cout = c; end
      4'd6: begin d = a >> 1; c = a[0];  cout = c; end
      4'd7: begin d = $unsigned($signed(a) >>> 1); c = a[0]; cout = c; end
`ifdef ALUSEQ_ADC32_EN
      4'd8: begin s = {1'b0,a} + {1'b0,b} + {32'd0,cin}; d = s[31:0]; c = s[32];
                  v = (a[31] == b[31]) && (d[31] != a[31]); cout = c; end
`endif
      default: err = 1'b1;
    endcase
    f = err ? 4'd0 : {(d == 32'd0), c, d[31], v};
  endfunction

  // pass table: function and operand half seen on the ALU pins for pass p
  function automatic logic [4:0] exp_fs(input logic [3:0] op, input int p);
    case (op)
      4'd0: return (p == 0) ? 5'b10100 : 5'b10101;
      4'd1: return (p == 0) ? 5'b10110 : 5'b10101;
      4'd2: return 5'b10111;
      4'd3: return 5'b11000;
      4'd4: return 5'b11001;
      4'd5: return (p == 0) ? 5'b11011 : 5'b11110;
      4'd6: return (p == 0) ? 5'b11100 : 5'b11111;
      4'd7: return (p == 0) ? 5'b11101 : 5'b11111;
      default: return 5'b10101;
    endcase
  endfunction

  // One full command: accept, passes, optional back-pressure, handshake out.
  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
    logic [31:0] ed;
    logic [3:0]  ef;
    logic        ee, ec;
    logic [4:0]  fs_obs [2];
    logic [15:0] a_obs [2];
    int lat, wfc;
    ref_op(op, a, b, mdl_c, ed, ef, ee, ec);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    chk("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_a = $urandom; bus.cmd_b = $urandom;
    lat = 1; wfc = 0;
    while (!bus.rsp_valid && lat < 10) begin
      if (bus.alu_wf) begin
        if (wfc < 2) begin fs_obs[wfc] = bus.alu_funsel; a_obs[wfc] = bus.alu_a; end
        wfc++;
      end
      @(posedge clk); #1;
      lat++;
    end
    // RspValid rises on the third edge counting the accept edge; illegal ops on the accept edge
    chk("latency", lat, ee ? 32'd1 : 32'd3);
    chk("wf_passes", wfc, ee ? 32'd0 : 32'd2);
    if (!ee && wfc == 2) begin
      for (int p = 0; p < 2; p++) begin
        logic hi;
        hi = ((op == 4'd6) || (op == 4'd7)) ? (p == 0) : (p == 1);
        chk($sformatf("funsel_p%0d", p), {27'd0, fs_obs[p]}, {27'd0, exp_fs(op, p)});
        chk($sformatf("alu_a_p%0d", p), {16'd0, a_obs[p]}, {16'd0, hi ? a[31:16] : a[15:0]});
      end
    end
    chk("rsp_data",  bus.rsp_data, ed);
    chk("rsp_flags", {28'd0, bus.rsp_flags}, {28'd0, ef});
    chk("rsp_err",   {31'd0, bus.rsp_err}, {31'd0, ee});
    for (int h = 0; h < hold; h++) begin
      bus.cmd_valid = 1'b1; bus.cmd_op = 4'd0;
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_data",  bus.rsp_data, ed);
      chk("hold_flags", {28'd0, bus.rsp_flags}, {28'd0, ef});
      chk("hold_ready", {31'd0, bus.cmd_ready}, 32'd0);
      chk("hold_wf",    {31'd0, bus.alu_wf}, 32'd0);
    end
    // command still offered on the release edge must not be taken
    bus.cmd_valid = 1'b1; bus.cmd_op = 4'd0; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("release_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("release_wf",    {31'd0, bus.alu_wf}, 32'd0);
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
    mdl_c = ec;
  endtask

  initial begin
    logic [3:0] op;
    logic [31:0] a, b;
    int r;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 4'd0; bus.cmd_a = 32'd0; bus.cmd_b = 32'd0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data",  bus.rsp_data, 32'd0);
    chk("rst_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_alu_ab",    {bus.alu_a, bus.alu_b}, 32'd0);
    chk("rst_funsel",    {27'd0, bus.alu_funsel}, 32'h10);
    chk("rst_wf",        {31'd0, bus.alu_wf}, 32'd0);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases from the pass table corners
    run_cmd(4'd0, 32'h0000_FFFF, 32'h0000_0001, 0);
    run_cmd(4'd1, 32'h0001_0000, 32'h0000_0001, 0);
    run_cmd(4'd1, 32'h0000_0000, 32'h0000_0001, 0);
    run_cmd(4'd6, 32'h0001_0001, 32'h0, 0);
    run_cmd(4'd7, 32'h8000_0000, 32'h0, 0);
    run_cmd(4'd5, 32'h8000_8000, 32'h0, 0);
    run_cmd(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5);
    run_cmd(4'hF, 32'h1234_5678, 32'h1, 1);
    run_cmd(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_cmd(4'd8, 32'h0000_0001, 32'h0000_0001, 0);

    // reset while the high pass is on the ALU pins aborts the command
    bus.cmd_valid = 1'b1; bus.cmd_op = 4'd0; bus.cmd_a = 32'h1234_5678; bus.cmd_b = 32'h1111_1111;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_pre_wf", {31'd0, bus.alu_wf}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("abort_wf",    {31'd0, bus.alu_wf}, 32'd0);
    chk("abort_ready", {31'd0, bus.cmd_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(4'd0, 32'h0000_FFFF, 32'h0000_0001, 0);

    // randomized ops and operands
    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 24);
      op = (r < 18) ? 4'(r % 9) : 4'(r - 9);
      a  = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      b  = ($urandom_range(0, 4) == 0) ? 32'h0000_0001 : 32'($urandom);
      run_cmd(op, a, b, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
